// File: rtl/radix2_div_pkg.sv
// Shared widths and FSM encoding for the radix-2 restoring divider.
package radix2_div_pkg;

  localparam int unsigned DivXlen = 64;
  localparam int unsigned DivCntW = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/radix2_div_step.sv
// One restoring-division step: shift in a dividend bit and trial-subtract the divisor.
module radix2_div_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN+1:0] diff;

  // One extra bit so the sign of the trial difference is always representable.
  assign diff     = {rem, bit_in} - {2'b00, dvs};
  assign q_bit    = ~diff[XLEN+1];
  assign rem_next = q_bit ? diff[XLEN:0] : {rem[XLEN-1:0], bit_in};

endmodule

// File: rtl/radix2_div.sv
// Iterative restoring radix-2 divider for the RV64M DIV/REM family, one quotient bit per cycle.
module radix2_div
  import radix2_div_pkg::*;
#(
  parameter int unsigned XLEN  = DivXlen,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            word_q;

  logic [XLEN-1:0] a_prep, b_prep, a_mag, b_mag, a_dz_rem;
  logic            a_neg, b_neg, accept;
  logic [XLEN:0]   rem_nxt;
  logic            q_bit;
  logic [XLEN-1:0] quo_nxt, q_fix, r_fix, q_out, r_out;

  assign div_ready = (state == StIdle);
  assign out_valid = (state == StDone);
  assign accept    = div_valid & div_ready & ~flush;

  always_comb begin
    a_prep = dividend;
    b_prep = divisor;
    if (div_word) begin
      a_prep = {{(XLEN-32){div_signed & dividend[31]}}, dividend[31:0]};
      b_prep = {{(XLEN-32){div_signed & divisor[31]}}, divisor[31:0]};
    end
  end

  assign a_neg    = div_signed & a_prep[XLEN-1];
  assign b_neg    = div_signed & b_prep[XLEN-1];
  assign a_mag    = a_neg ? -a_prep : a_prep;
  assign b_mag    = b_neg ? -b_prep : b_prep;
  // W-form results are always sign-extended from bit 31, even for unsigned ops.
  assign a_dz_rem = div_word ? {{(XLEN-32){a_prep[31]}}, a_prep[31:0]} : a_prep;

  radix2_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (rem_q),
    .bit_in  (quo_q[XLEN-1]),
    .dvs     (dvs_q),
    .rem_next(rem_nxt),
    .q_bit   (q_bit)
  );

  assign quo_nxt = {quo_q[XLEN-2:0], q_bit};
  assign q_fix   = neg_q_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
  assign q_out   = word_q ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
  assign r_out   = word_q ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      word_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            word_q  <= div_word;
            if (b_prep == '0) begin
              quotient  <= '1;
              remainder <= a_dz_rem;
              state     <= StDone;
            end else begin
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            quotient  <= q_out;
            remainder <= r_out;
            state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// Directed bench for radix2_div: hand-computed quotients/remainders, latency, flush and reset.
module tb_radix2_div;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, div_ready, div_signed, div_word;
  logic [63:0] dividend, divisor, quotient, remainder;
  logic        out_valid, out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  radix2_div u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_signed(div_signed),
    .div_word  (div_word),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start_op(input logic s, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    div_signed = s;
    div_word   = w;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic s, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_q,
                       input logic [63:0] exp_r, input int exp_lat, input int hold);
    int lat;
    check({tag, ".ready"}, 64'(div_ready), 64'd1);
    start_op(s, w, a, b);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".q"}, quotient, exp_q);
    check({tag, ".r"}, remainder, exp_r);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, ".hold_v"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_q"}, quotient, exp_q);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drain_v"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 64'(div_ready), 64'd1);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.q", quotient, 64'd0);
    check("rst.r", remainder, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 10);
    do_op("s-7_2", 1'b1, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("s7_-2", 1'b1, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 0);
    do_op("u_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF,
          64'hF, 65, 0);
    do_op("dz", 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 0);
    do_op("dz_w", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, 65, 0);
    do_op("ovf_w", 1'b1, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'd0, 65, 0);
    do_op("wu_mask", 1'b0, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000,
          64'd0, 65, 0);
    do_op("ws_mask", 1'b1, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFFF, 65, 0);

    // Flush mid-CALC: the aborted op must never produce a result.
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (29) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl_calc.valid", 64'(out_valid), 64'd0);
    check("fl_calc.ready", 64'(div_ready), 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("fl_calc.never", 64'(seen), 64'd0);
    do_op("fl_b2b", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 0);

    // Flush while a result is held in DONE.
    start_op(1'b0, 1'b0, 64'd9, 64'd0);
    check("fl_done.pre", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("fl_done.valid", 64'(out_valid), 64'd0);
    check("fl_done.ready", 64'(div_ready), 64'd1);

    // A request presented together with flush is dropped.
    div_valid = 1'b1;
    divisor   = 64'd0;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    flush     = 1'b0;
    check("fl_req.valid", 64'(out_valid), 64'd0);
    check("fl_req.ready", 64'(div_ready), 64'd1);

    // Asynchronous reset mid-CALC takes effect without a clock edge.
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.ready", 64'(div_ready), 64'd1);
    check("arst.q", quotient, 64'd0);
    check("arst.r", remainder, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op("post_rst", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/radix2_div.md
Name: radix2_div

Overview:
- Iterative restoring radix-2 divider for the RV64M divide/remainder group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Multi-cycle counterpart to the single-cycle multiplier. Sits beside it in the execute stage.
- Accepts one operation per valid/ready handshake and produces quotient and remainder together.
- Holds the result until the consumer takes it. Supports flush from the pipeline.

Parameters:
- XLEN, 64, operand/result width; equals `REG_BUS` width.
- CNT_W, 7, iteration counter width; ceil(log2(XLEN)) + 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  abort any in-flight or held operation.
- div_valid  input  1  request valid.
- div_ready  output  1  divider can accept; high only in IDLE.
- div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned.
- div_word  input  1  1 = W-form; use the low 32 bits of each operand.
- dividend  input  [`REG_BUS]  rs1 value.
- divisor  input  [`REG_BUS]  rs2 value.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  [`REG_BUS]  quotient.
- remainder  output  [`REG_BUS]  remainder.

Behaviour:
- Reset: state=IDLE; div_ready=1; out_valid=0; quotient=0; remainder=0; counter=0.
- States:
  - IDLE: div_ready=1. A handshake (div_valid & div_ready) latches operands.
    - Divisor (after word masking) == 0 → DONE.
    - Otherwise → CALC.
  - CALC: one quotient bit per cycle, MSB first. Counter counts 0..XLEN-1. When counter==XLEN-1 → DONE, with sign-corrected results registered on that edge.
  - DONE: out_valid=1; quotient/remainder stable. On out_ready → IDLE. In IDLE, out_valid=0 and the data outputs hold their last values.
- Operand preparation at the accept edge:
  - Word mode: each operand's low 32 bits are sign-extended (div_signed=1) or zero-extended (div_signed=0) to XLEN.
  - Signed: record neg_q = sign(a) ^ sign(b) and neg_r = sign(a); store magnitudes.
  - Unsigned: store raw values; neg flags = 0.
- Iteration:
  - Partial remainder is XLEN+1 bits.
  - Each step: shift {rem, quo} left by 1; trial subtract divisor magnitude; if non-negative, keep the difference and set quotient LSB=1.
- Sign fix on the final edge: negate the quotient if neg_q; negate the remainder if neg_r.
- Word mode output: both results are the sign-extension of bit 31 of the computed result, for signed and unsigned forms.
- Latency:
  - Normal: out_valid rises XLEN+1 = 65 rising edges after the accepting edge.
  - Divide-by-zero: out_valid rises 1 edge after the accepting edge.
- Divide-by-zero: quotient = all ones (all XLEN bits; also all ones for W forms after sign-extension); remainder = prepared dividend (word mode: sign-extended low 32 bits).
- Signed overflow (most-negative / -1): no special path. The magnitude algorithm yields quotient = dividend and remainder = 0; word form gives 0xFFFFFFFF80000000 and 0.
- Handshake:
  - No new request is accepted while in CALC or DONE.
  - out_ready is ignored outside DONE.
  - In DONE, out_valid & out_ready → IDLE on the next edge. No same-cycle accept; the next request is accepted one cycle later.
- Flush:
  - Any state → IDLE on the next edge; out_valid=0; any held result is discarded.
  - Flush has priority over out_ready and div_valid in the same cycle. A request presented with flush is not accepted.
- Asynchronous rst mid-operation: immediate return to the reset values; no partial result is emitted.

Decomposition:
- defines.v: add `DIV_CNT_BUS` (CNT_W-1:0) and an IDLE/CALC/DONE state encoding macro set. Reuse `REG_BUS`.
- One combinational sub-module, div_step: inputs are the partial remainder, the quotient bit shifted in, and the divisor magnitude; outputs are the next remainder and the quotient bit. Instantiated once per cycle, not unrolled.

Test Plan:
- Unsigned 100 / 7 (div_signed=0, div_word=0) → quotient=14, remainder=2; out_valid exactly 65 edges after the handshake; held while out_ready=0 for 10 cycles.
- Signed -7 / 2 → quotient=0xFFFFFFFFFFFFFFFD (-3), remainder=0xFFFFFFFFFFFFFFFF (-1). Signed 7 / -2 → quotient=-3, remainder=1.
- Divide-by-zero: 5 / 0 → quotient=0xFFFFFFFFFFFFFFFF, remainder=5, out_valid 1 edge after accept. Word signed 0x00000000_80000000 / 0 → remainder=0xFFFFFFFF80000000.
- Overflow cases:
  - Signed 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → quotient=0x8000000000000000, remainder=0.
  - Word signed 0x12345678_80000000 / 0xFFFFFFFF → quotient=0xFFFFFFFF80000000, remainder=0.
- Word-mode upper-bit masking:
  - Word unsigned 0xDEADBEEF_80000000 / 1 → quotient=0xFFFFFFFF80000000, remainder=0.
  - Word signed 0xAAAAAAAA_FFFFFFF9 / 2 → quotient=0xFFFFFFFFFFFFFFFD.
- Flush and reset:
  - Flush in CALC (iteration 30) → out_valid never rises; div_ready=1 on the next edge; a back-to-back 100/7 returns the correct result.
  - Flush in DONE while out_ready=0 → result is discarded.
  - rst pulse mid-CALC → all outputs at reset values immediately.
